// File: rtl/entity_pixel_renderer_pkg.sv
// Shared constants for the pacman video path: entity codes, directions,
// sprite ids in the sprite ROM, fixed colours and the 16-entry palette.
package pacman_pkg;

    // Entity codes carried on the per-pixel entity-select bus
    localparam logic [6:0] ENT_NONE     = 7'd0;
    localparam logic [6:0] ENT_PACMAN   = 7'd1;
    localparam logic [6:0] ENT_MAZE     = 7'd2;
    localparam logic [6:0] ENT_BLINKY   = 7'd3;
    localparam logic [6:0] ENT_PINKY    = 7'd4;
    localparam logic [6:0] ENT_INKY     = 7'd5;
    localparam logic [6:0] ENT_CLYDE    = 7'd6;
    localparam logic [6:0] ENT_PELLET   = 7'd7;
    localparam logic [6:0] ENT_ONES     = 7'd8;
    localparam logic [6:0] ENT_TENS     = 7'd9;
    localparam logic [6:0] ENT_HUNS     = 7'd10;
    localparam logic [6:0] ENT_THOUS    = 7'd11;
    localparam logic [6:0] ENT_TENTHOUS = 7'd12;
    localparam logic [6:0] ENT_CHERRY   = 7'd15;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    // Base sprite ids; pacman and ghosts add their animation phase bit
    localparam logic [4:0] SPRITE_ID_PACMAN = 5'd0;
    localparam logic [4:0] SPRITE_ID_GHOST  = 5'd2;
    localparam logic [4:0] SPRITE_ID_CHERRY = 5'd4;
    localparam logic [4:0] SPRITE_ID_DIGIT  = 5'd16;

    localparam logic [23:0] COL_BLACK  = 24'h000000;
    localparam logic [23:0] COL_MAZE   = 24'h2121DE;
    localparam logic [23:0] COL_PELLET = 24'hFFB897;
    localparam logic [23:0] COL_PACMAN = 24'hFFFF00;
    localparam logic [23:0] COL_BLINKY = 24'hFF0000;
    localparam logic [23:0] COL_PINKY  = 24'hFFB8FF;
    localparam logic [23:0] COL_INKY   = 24'h00FFFF;
    localparam logic [23:0] COL_CLYDE  = 24'hFFB852;

    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'hFF0000, 24'hFFFFFF, 24'h2121DE,
        24'hFFB897, 24'hDE9751, 24'h00FF00, 24'hFFB8FF,
        24'h00FFFF, 24'hFFB852, 24'h808080, 24'h0000FF,
        24'hFF8000, 24'h800080, 24'hC0C0C0, 24'h404040
    };

    // Entities that are drawn from the sprite ROM
    function automatic logic is_sprite_ent(input logic [6:0] ent);
        case (ent)
            ENT_PACMAN, ENT_BLINKY, ENT_PINKY, ENT_INKY, ENT_CLYDE, ENT_CHERRY,
            ENT_ONES, ENT_TENS, ENT_HUNS, ENT_THOUS, ENT_TENTHOUS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Colour used for palette index 1 of a sprite entity
    function automatic logic [23:0] body_colour(input logic [6:0] ent);
        case (ent)
            ENT_PACMAN: return COL_PACMAN;
            ENT_BLINKY: return COL_BLINKY;
            ENT_PINKY:  return COL_PINKY;
            ENT_INKY:   return COL_INKY;
            ENT_CLYDE:  return COL_CLYDE;
            default:    return PALETTE[1];
        endcase
    endfunction

endpackage

// File: rtl/entity_pixel_renderer_sprite_addr_gen.sv
// Combinational sprite ROM address: texel offset inside the 16x16 sprite,
// pacman orientation by direction, and sprite id selection.
module sprite_addr_gen
    import pacman_pkg::*;
#(
    parameter int ROM_AW = 13
) (
    input  logic [9:0]        i_draw_x,
    input  logic [9:0]        i_draw_y,
    input  logic [9:0]        i_ent_x,
    input  logic [9:0]        i_ent_y,
    input  logic [6:0]        i_entity,
    input  logic [1:0]        i_dir,
    input  logic [3:0]        i_digit,
    input  logic              i_mouth,
    input  logic              i_skirt,
    output logic [ROM_AW-1:0] o_rom_addr
);

    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic [3:0] w_col;
    logic [3:0] w_row;
    logic [4:0] w_id;
    logic       w_unused;

    // Offsets wrap modulo 16; only the low nibble addresses the sprite
    assign w_dx     = i_draw_x - i_ent_x;
    assign w_dy     = i_draw_y - i_ent_y;
    assign w_unused = ^{w_dx[9:4], w_dy[9:4]};

    // Orient the pacman sprite; the ROM holds only the right-facing image.
    // Down uses the pre-swap row for both the new column and the mirrored row.
    always_comb begin
        w_col = w_dx[3:0];
        w_row = w_dy[3:0];
        if (i_entity == ENT_PACMAN) begin
            case (dir_e'(i_dir))
                DIR_LEFT: w_col = 4'd15 - w_dx[3:0];
                DIR_UP: begin
                    w_col = w_dy[3:0];
                    w_row = w_dx[3:0];
                end
                DIR_DOWN: begin
                    w_col = w_dy[3:0];
                    w_row = 4'd15 - w_dy[3:0];
                end
                default: ;
            endcase
        end
    end

    // Pick the sprite image; non-sprite entities point at sprite 0 (unused)
    always_comb begin
        w_id = 5'd0;
        case (i_entity)
            ENT_PACMAN: w_id = SPRITE_ID_PACMAN + {4'd0, i_mouth};
            ENT_BLINKY, ENT_PINKY, ENT_INKY, ENT_CLYDE:
                w_id = SPRITE_ID_GHOST + {4'd0, i_skirt};
            ENT_CHERRY: w_id = SPRITE_ID_CHERRY;
            ENT_ONES, ENT_TENS, ENT_HUNS, ENT_THOUS, ENT_TENTHOUS:
                w_id = (i_digit > 4'd9) ? SPRITE_ID_DIGIT : (SPRITE_ID_DIGIT + {1'b0, i_digit});
            default: w_id = 5'd0;
        endcase
    end

    assign o_rom_addr = {w_id, w_row, w_col};

endmodule

// File: rtl/entity_pixel_renderer.sv
// Entity pixel renderer: three-beat pixel pipeline (address, ROM read,
// colour), sprite animation phase counters and the sticky lose_game flag.
//
// Flow control: pix_en is a pure strobe. Every pipeline register advances
// exactly on cycles with pix_en=1 and holds otherwise; there is no ready or
// backpressure path, so the upstream producer must present one pixel per
// strobe and the ROM must hold rom_data while pix_en=0.
module entity_pixel_renderer
    import pacman_pkg::*;
#(
    parameter int ANIM_DIV = 8,
    parameter int ROM_AW   = 13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en,
    input  logic              blank_in,
    input  logic              vs,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [6:0]        entity,
    input  logic [9:0]        entityX,
    input  logic [9:0]        entityY,
    input  logic [1:0]        entityDir,
    input  logic [3:0]        digit_value,
    input  logic              lose_game_in,
    input  logic              game_restart,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              blank_out,
    output logic              lose_game
);

    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(ANIM_DIV - 1);

    logic [CW-1:0]     r_frame_cnt;
    logic              r_vs_d;
    logic              r_mouth;
    logic              r_skirt;
    logic              w_vs_fall;

    logic [ROM_AW-1:0] w_addr;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [6:0]        r_s0_ent;
    logic              r_s0_blank;
    logic              r_s0_vld;

    logic [3:0]        r_s1_idx;
    logic [6:0]        r_s1_ent;
    logic              r_s1_blank;
    logic              r_s1_vld;

    logic [23:0]       w_colour;
    logic [23:0]       r_rgb;
    logic              r_blank_out;
    logic              r_lose_game;

    assign w_vs_fall = r_vs_d & ~vs;

    // Count frames on vsync falling edges and flip the animation phase every ANIM_DIV frames
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_d      <= 1'b0;
            r_frame_cnt <= '0;
            r_mouth     <= 1'b0;
            r_skirt     <= 1'b0;
        end else begin
            r_vs_d <= vs;
            if (game_restart) begin
                r_frame_cnt <= '0;
                r_mouth     <= 1'b0;
                r_skirt     <= 1'b0;
            end else if (w_vs_fall) begin
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt <= '0;
                    r_mouth     <= ~r_mouth;
                    r_skirt     <= ~r_skirt;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    sprite_addr_gen #(
        .ROM_AW (ROM_AW)
    ) u_addr_gen (
        .i_draw_x   (DrawX),
        .i_draw_y   (DrawY),
        .i_ent_x    (entityX),
        .i_ent_y    (entityY),
        .i_entity   (entity),
        .i_dir      (entityDir),
        .i_digit    (digit_value),
        .i_mouth    (r_mouth),
        .i_skirt    (r_skirt),
        .o_rom_addr (w_addr)
    );

    // S0: register the ROM address and the pixel attributes that travel with it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_s0_ent   <= ENT_NONE;
            r_s0_blank <= 1'b0;
            r_s0_vld   <= 1'b0;
        end else if (pix_en) begin
            r_rom_addr <= w_addr;
            r_s0_ent   <= entity;
            r_s0_blank <= blank_in;
            r_s0_vld   <= 1'b1;
        end
    end

    // S1: capture the palette index returned by the ROM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_idx   <= 4'd0;
            r_s1_ent   <= ENT_NONE;
            r_s1_blank <= 1'b0;
            r_s1_vld   <= 1'b0;
        end else if (pix_en) begin
            r_s1_idx   <= rom_data;
            r_s1_ent   <= r_s0_ent;
            r_s1_blank <= r_s0_blank;
            r_s1_vld   <= r_s0_vld;
        end
    end

    // Colour for the pixel in S1; unknown entity codes render as background
    always_comb begin
        w_colour = COL_BLACK;
        if (r_s1_ent == ENT_MAZE) begin
            w_colour = COL_MAZE;
        end else if (r_s1_ent == ENT_PELLET) begin
            w_colour = COL_PELLET;
        end else if (is_sprite_ent(r_s1_ent)) begin
            if (r_s1_idx == 4'd0) begin
                w_colour = COL_BLACK;
            end else if (r_s1_idx == 4'd1) begin
                w_colour = body_colour(r_s1_ent);
            end else begin
                w_colour = PALETTE[r_s1_idx];
            end
        end
    end

    // S2: register the colour, forced black outside the visible area or while the pipe refills
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb       <= COL_BLACK;
            r_blank_out <= 1'b0;
        end else if (pix_en) begin
            r_rgb       <= (r_s1_vld && r_s1_blank) ? w_colour : COL_BLACK;
            r_blank_out <= r_s1_vld & r_s1_blank;
        end
    end

    // Sticky collision flag; a restart in the same cycle as a hit clears it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lose_game <= 1'b0;
        end else if (game_restart) begin
            r_lose_game <= 1'b0;
        end else if (pix_en && blank_in && lose_game_in) begin
            r_lose_game <= 1'b1;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign Red       = r_rgb[23:16];
    assign Green     = r_rgb[15:8];
    assign Blue      = r_rgb[7:0];
    assign blank_out = r_blank_out;
    assign lose_game = r_lose_game;

endmodule
